// File: rtl/scan_chain_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_chain_ctrl_pkg                                                 |
// | FSM states and chain orientation shared by the scan controller.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package scan_chain_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        RESP    = 3'd4
    } state_e;

    // Flop 0 is the one fed by scan_d_o; parallel bit k always maps to flop k,
    // so this index is also the serial-in end of every shift register.
    localparam int unsigned C_SCAN_IN_FLOP = 0;

endpackage
`default_nettype wire

// File: rtl/scan_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_shift_reg                                                      |
// | Parallel-load, parallel-read shift register; shifts toward the MSB. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module scan_shift_reg
    import scan_chain_ctrl_pkg::*;
#(
    parameter int ChainLen = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [ChainLen-1:0] load_data_i,
    input  logic                shift_i,
    input  logic                ser_i,
    output logic                ser_o,
    output logic [ChainLen-1:0] data_o
);

    logic [ChainLen-1:0] data_q;
    logic [ChainLen-1:0] w_shift_nxt;

    always_comb begin
        w_shift_nxt                 = {data_q[ChainLen-2:0], 1'b0};
        w_shift_nxt[C_SCAN_IN_FLOP] = ser_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= w_shift_nxt;
        end
    end

    assign ser_o  = data_q[ChainLen-1];
    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_chain_ctrl                                                     |
// | Loads/unloads one scan chain with an optional functional capture.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int ChainLen = 8,
    parameter int CntWidth = $clog2(ChainLen + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ChainLen-1:0] req_data_i,
    input  logic                req_capture_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [ChainLen-1:0] rsp_data_o,
    output logic                scan_en_o,
    output logic                scan_d_o,
    output logic                dis_o,
    input  logic                scan_q_i
);

    localparam logic [CntWidth-1:0] C_LAST_CNT = CntWidth'(ChainLen - 1);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  capture_q;
    logic                  w_accept;
    logic                  w_shifting;
    logic                  w_pass_end;
    logic                  w_load_ser;
    logic                  w_rsp_ser_unused;
    logic [ChainLen-1:0]   w_load_vec_unused;

    assign w_accept   = (state_q == IDLE) && req_valid_i;
    assign w_shifting = (state_q == LOAD) || (state_q == UNLOAD);
    assign w_pass_end = (cnt_q == C_LAST_CNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = LOAD;
            LOAD:    if (w_pass_end) state_d = capture_q ? CAPTURE : RESP;
            CAPTURE: state_d = UNLOAD;
            UNLOAD:  if (w_pass_end) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
        scan_en_o   = w_shifting;
        dis_o       = w_shifting || (state_q == RESP);
        scan_d_o    = w_shifting && w_load_ser;
    end

    // Counter saturates at the last shift cycle; IDLE and CAPTURE clear it for the next pass.
    always_comb begin
        cnt_d = cnt_q;
        if (w_shifting) begin
            if (!w_pass_end) cnt_d = cnt_q + 1'b1;
        end else if ((state_q == IDLE) || (state_q == CAPTURE)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            capture_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (w_accept) capture_q <= req_capture_i;
        end
    end

    // Rotating the load vector restores it after LOAD so UNLOAD can shift it in again.
    scan_shift_reg #(.ChainLen(ChainLen)) u_load_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (w_accept),
        .load_data_i (req_data_i),
        .shift_i     (w_shifting),
        .ser_i       (w_load_ser),
        .ser_o       (w_load_ser),
        .data_o      (w_load_vec_unused)
    );

    scan_shift_reg #(.ChainLen(ChainLen)) u_rsp_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (1'b0),
        .load_data_i ({ChainLen{1'b0}}),
        .shift_i     (w_shifting),
        .ser_i       (scan_q_i),
        .ser_o       (w_rsp_ser_unused),
        .data_o      (rsp_data_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_scan_chain_ctrl                                                  |
// | Self-checking bench with behavioural hold/scan/DFF chain models.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0, req_ready, req_cap = 1'b0;
    logic [N-1:0] req_data = '0, rsp_data;
    logic         rsp_valid, rsp_ready = 1'b0;
    logic         scan_en, scan_d, dis, scan_q;
    logic [N-1:0] chain8, func_d8 = '0;

    logic         req_valid2 = 1'b0, req_ready2, req_cap2 = 1'b0;
    logic [1:0]   req_data2 = '0, rsp_data2;
    logic         rsp_valid2, rsp_ready2 = 1'b0;
    logic         scan_en2, scan_d2, dis2, scan_q2;
    logic [1:0]   chain2, func_d2 = '0;

    int errors = 0;
    int checks = 0;

    scan_chain_ctrl #(.ChainLen(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_data_i(req_data), .req_capture_i(req_cap),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .scan_en_o(scan_en), .scan_d_o(scan_d), .dis_o(dis), .scan_q_i(scan_q)
    );

    scan_chain_ctrl #(.ChainLen(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid2), .req_ready_o(req_ready2),
        .req_data_i(req_data2), .req_capture_i(req_cap2),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_data_o(rsp_data2),
        .scan_en_o(scan_en2), .scan_d_o(scan_d2), .dis_o(dis2), .scan_q_i(scan_q2)
    );

    // Each chain flop: scan mux overrides hold mux, hold mux overrides functional D.
    always @(posedge clk) begin
        chain8 <= scan_en ? {chain8[N-2:0], scan_d} : (dis ? chain8 : func_d8);
        chain2 <= scan_en2 ? {chain2[0], scan_d2} : (dis2 ? chain2 : func_d2);
    end
    assign scan_q  = chain8[N-1];
    assign scan_q2 = chain2[1];

    typedef struct {
        logic [N-1:0] data;
        logic         cap;
        logic [N-1:0] func;
        logic [N-1:0] pre;
        int           delay;
        logic [N-1:0] exp_rsp;
        int           exp_lat;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] ref_rsp(input logic cap, input logic [N-1:0] func,
                                             input logic [N-1:0] pre);
        return cap ? func : pre;
    endfunction

    function automatic int ref_lat(input logic cap);
        return cap ? 2 * N + 2 : N + 1;
    endfunction

    // Called at the negedge just after the accept edge (cycle 1).
    task automatic wait_rsp(output int lat, output int ns, output int ng, output int br);
        lat = 1; ns = 0; ng = 0; br = 0;
        while (!rsp_valid && lat < 200) begin
            if (scan_en) ns++;
            else if (ns > 0) ng++;
            if (req_ready) br++;
            @(negedge clk);
            lat++;
        end
        chk("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic run_req(input string nm, input logic [N-1:0] d, input logic cap,
                           input logic [N-1:0] fd, input logic [N-1:0] pre,
                           input int delay, input logic [N-1:0] exp_rsp, input int exp_lat);
        int lat, ns, ng, br, bad;
        func_d8   = pre;
        rsp_ready = (delay == 0);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_data = d; req_cap = cap;
        @(negedge clk);
        req_valid = 1'b0; req_data = N'($urandom); req_cap = 1'($urandom); func_d8 = fd;
        wait_rsp(lat, ns, ng, br);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_rsp_data"}, rsp_data, exp_rsp);
        chk({nm, "_chain"}, chain8, d);
        chk({nm, "_scan_cycles"}, ns, cap ? 2 * N : N);
        chk({nm, "_capture_gap"}, ng, cap ? 1 : 0);
        chk({nm, "_busy_ready"}, br, 0);
        bad = 0;
        for (int i = 0; i < delay; i++) begin
            func_d8 = N'($urandom);
            @(negedge clk);
            if (rsp_data !== exp_rsp || dis !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b1)
                bad++;
        end
        if (delay > 0) begin
            chk({nm, "_hold"}, bad, 0);
            chk({nm, "_chain_frozen"}, chain8, d);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_idle_after"}, {rsp_valid, req_ready}, 2'b01);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, ns, ng, br;
        logic [1:0] seq;
        logic [N-1:0] d, fd, pre;
        logic cap;

        tbl[0] = '{data: 8'hC3, cap: 1'b0, func: 8'h00, pre: 8'h5A, delay: 0, exp_rsp: 8'h5A, exp_lat: 9};
        tbl[1] = '{data: 8'h0F, cap: 1'b1, func: 8'hA5, pre: 8'h33, delay: 0, exp_rsp: 8'hA5, exp_lat: 18};
        tbl[2] = '{data: 8'h81, cap: 1'b1, func: 8'h3C, pre: 8'hFF, delay: 5, exp_rsp: 8'h3C, exp_lat: 18};
        tbl[3] = '{data: 8'h00, cap: 1'b0, func: 8'h00, pre: 8'hFF, delay: 5, exp_rsp: 8'hFF, exp_lat: 9};

        #1;
        chk("reset_outputs", {req_ready, rsp_valid, scan_en, scan_d, dis}, 5'b10000);
        chk("reset_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            run_req($sformatf("vec%0d", i), tbl[i].data, tbl[i].cap, tbl[i].func,
                    tbl[i].pre, tbl[i].delay, tbl[i].exp_rsp, tbl[i].exp_lat);

        // Second request raised mid-LOAD must wait until IDLE.
        func_d8 = 8'h11;
        @(negedge clk); @(negedge clk);
        req_valid = 1'b1; req_data = 8'h3C; req_cap = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        req_valid = 1'b1; req_data = 8'hFF; req_cap = 1'b0;
        chk("midload_ready", req_ready, 0);
        wait_rsp(lat, ns, ng, br);
        chk("midload_first_rsp", rsp_data, 8'h11);
        chk("midload_busy_ready", br, 0);
        func_d8 = 8'h3C;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midload_idle", req_ready, 1);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, ns, ng, br);
        chk("midload_second_rsp", rsp_data, 8'h3C);
        chk("midload_second_chain", chain8, 8'hFF);
        chk("midload_second_lat", lat, N + 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Asynchronous reset in cycle 4 of LOAD.
        func_d8 = 8'h00;
        @(negedge clk);
        req_valid = 1'b1; req_data = 8'h96; req_cap = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {req_ready, rsp_valid, scan_en, scan_d, dis}, 5'b10000);
        chk("async_rst_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        run_req("after_rst", 8'h2B, 1'b1, 8'hE4, 8'h00, 1, 8'hE4, 18);

        for (int i = 0; i < 20; i++) begin
            d   = N'($urandom);
            fd  = N'($urandom);
            pre = N'($urandom);
            cap = 1'($urandom_range(0, 1));
            run_req($sformatf("rnd%0d", i), d, cap, fd, pre, $urandom_range(0, 3),
                    ref_rsp(cap, fd, pre), ref_lat(cap));
        end

        // Two-flop chain: counter boundary.
        func_d2 = 2'b01;
        @(negedge clk); @(negedge clk);
        req_valid2 = 1'b1; req_data2 = 2'b10; req_cap2 = 1'b0;
        @(negedge clk);
        req_valid2 = 1'b0; func_d2 = 2'b11;
        lat = 1; ns = 0; seq = 2'b00;
        while (!rsp_valid2 && lat < 50) begin
            if (scan_en2) begin
                ns++;
                seq = {seq[0], scan_d2};
            end
            @(negedge clk);
            lat++;
        end
        chk("len2_latency", lat, 3);
        chk("len2_scan_cycles", ns, 2);
        chk("len2_scan_d_seq", seq, 2'b10);
        chk("len2_rsp_data", rsp_data2, 2'b01);
        chk("len2_chain", chain2, 2'b10);
        rsp_ready2 = 1'b1;
        @(negedge clk);
        chk("len2_idle_after", {rsp_valid2, req_ready2}, 2'b01);
        rsp_ready2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
